mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit for the RV64M extension. Sits in the execute stage beside `alu` and takes the same forwarded operand pair and `word32` flag. Its result replaces the ALU result on the path into the EX/MEM register. While an operation is in flight it stalls the front of the pipeline.

## Interface
Parameters: none (XLEN fixed at 64 via `data_t`).

Ports:
- `clk`  in  1  — clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start_i`  in  1  — execute stage holds a valid M-extension instruction.
- `flush_i`  in  1  — pipeline flush; kills any in-flight operation.
- `mdop_i`  in  `mdop_t`  — operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `word32_i`  in  1  — W variant (MULW/DIVW/DIVUW/REMW/REMUW).
- `a_i`  in  64  — rs1 operand (`data_t`).
- `b_i`  in  64  — rs2 operand (`data_t`).
- `stall_o`  out  1  — combinational: hold IF/ID/EX.
- `valid_o`  out  1  — result valid this cycle.
- `res_o`  out  64  — result (`data_t`).

## Operation
- State machine `IDLE`, `CALC`, `DONE`; state reset value is `IDLE`.
- **IDLE:**
  - `start_i && !flush_i` latches the opcode, the `word32` flag, operand magnitudes and result sign, and clears the counter.
  - Divide special cases go straight to `DONE`. All other operations go to `CALC`.
- **CALC:**
  - One iteration per cycle. MUL uses radix-2 shift-add into a 128-bit accumulator. DIV uses radix-2 restoring division.
  - Iteration count N is 64, or 32 when `word32` is set.
  - Counter is 6 bits. The last iteration is at cnt == N-1, after which the state moves to `DONE`.
- **DONE:**
  - `valid_o`=1 for exactly one cycle and `res_o` is driven.
  - Next state is `IDLE`.
  - `res_o` holds its value until the next `DONE`.
- `flush_i` in any state forces `IDLE` on the next edge with no `valid_o`. Flush has priority over start.
- `stall_o` = (`IDLE` && `start_i` && !`flush_i`) || `CALC`. It is 0 in `DONE`, so the pipeline advances exactly when `valid_o`=1.
- **Signedness:**
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Iteration runs on magnitudes. Negation is applied at the end: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- **Result select:** MUL gives product[63:0]. MULH* gives product[127:64]. DIV* gives the quotient. REM* gives the remainder.
- **W variants:**
  - Operands use a_i[31:0] and b_i[31:0], sign- or zero-extended according to the op.
  - Result is bits [31:0] sign-extended to 64.
  - `word32` with MULH* is not decoded upstream; the unit ignores `word32` for MULH*.
- **Special cases** (checked at width 32 or 64 according to `word32`):
  - Divisor 0: quotient is all-ones, remainder is the dividend.
  - Signed overflow (most-negative / -1): quotient is the dividend, remainder is 0.

## Timing
- Accept at edge t, from `IDLE` with `start_i`.
- Normal op: `CALC` runs t+1..t+N, and `valid_o` is asserted in cycle t+N+1. That is 66 cycles for 64-bit, 34 for word.
- Special case: `valid_o` is asserted in cycle t+1.
- Back-to-back: a new `start_i` is sampled only in `IDLE`, so there is at least one cycle between `DONE` and the next accept.
- **Reset values:**
  - state `IDLE`, counter 0.
  - `valid_o` 0, `res_o` 0.
  - All datapath registers 0.
  - `stall_o` follows its combinational equation.
- Reset asserted mid-`CALC`: returns to `IDLE` immediately (asynchronous), with no `valid_o`.

## Structure
- `mdop_t`, the `MD_*` opcode constants and the `md_state_t` enum go in `def_cpu.svh`, alongside `aluop_t` and `data_t`.
- One sub-module: `mdu_div_step`, a combinational single restoring-division step of the form (rem, quo, divisor) → (rem', quo').
- The multiply step and sign fix-up stay inline.

## Test plan
- MUL, a=3, b=-5 (0xFFFF_FFFF_FFFF_FFFB) → `res_o`=0xFFFF_FFFF_FFFF_FFF1; `valid_o` at t+65; `stall_o` high t..t+64.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands → 0.
- DIV, b=0, a=7 → 0xFFFF_FFFF_FFFF_FFFF at t+1; REM with the same operands → 7.
- DIV, a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000; REM → 0. DIVW a=0x8000_0000, b=-1 → 0xFFFF_FFFF_8000_0000.
- DIVUW, a=0xFFFF_FFFF, b=2 → 0x0000_0000_7FFF_FFFF at t+33; REMW a=-7, b=2 → -1.
- `flush_i` pulsed at t+10 during DIV → `IDLE` at t+11, `valid_o` never asserts, `stall_o` low; the next start completes normally. Async `rst` mid-`CALC` gives the same result.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the RV64M iterative multiply/divide unit.
// Holds the operation encoding, FSM states and operand-class predicates.
package mdu_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  function automatic data_t sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_div(input mdop_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_mulh(input mdop_t op);
    return op inside {MD_MULH, MD_MULHSU, MD_MULHU};
  endfunction

  function automatic logic a_signed(input mdop_t op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic b_signed(input mdop_t op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step
  import mdu_pkg::*;
(
  input  data_t rem,
  input  data_t quo,
  input  data_t divisor,
  output data_t rem_next,
  output data_t quo_next
);

  logic [64:0] shifted;
  logic        fits;

  always_comb begin
    shifted  = {rem, quo[63]};
    fits     = shifted >= {1'b0, divisor};
    // rem < divisor on entry, so the true difference always fits in 64 bits.
    rem_next = fits ? (shifted[63:0] - divisor) : shifted[63:0];
    quo_next = {quo[62:0], fits};
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, with sign fix-up on the final step.
module mdu
  import mdu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start_i,
  input  logic  flush_i,
  input  mdop_t mdop_i,
  input  logic  word32_i,
  input  data_t a_i,
  input  data_t b_i,
  output logic  stall_o,
  output logic  valid_o,
  output data_t res_o
);

  md_state_t    state;
  mdop_t        op_q;
  logic         w32_q, neg_q, sa_q;
  data_t        opnd_q;
  logic [127:0] acc_q;  // mul: {hi, multiplier}; div: {remainder, quotient}
  logic [5:0]   cnt;

  logic  w32_in, sa, sb, special;
  data_t a_ext, b_ext, a_mag, b_mag, a_sel, spec_res;

  always_comb begin
    // NOTE: every signal gets a value on every path so no latch is inferred.
    w32_in   = word32_i && !is_mulh(mdop_i);
    sa       = a_signed(mdop_i) && (w32_in ? a_i[31] : a_i[63]);
    sb       = b_signed(mdop_i) && (w32_in ? b_i[31] : b_i[63]);
    a_ext    = w32_in ? {{32{sa}}, a_i[31:0]} : a_i;
    b_ext    = w32_in ? {{32{sb}}, b_i[31:0]} : b_i;
    a_mag    = sa ? -a_ext : a_ext;
    b_mag    = sb ? -b_ext : b_ext;
    a_sel    = w32_in ? sext32(a_i[31:0]) : a_i;
    special  = 1'b0;
    spec_res = '0;
    if (is_div(mdop_i)) begin
      if (w32_in ? (b_i[31:0] == 32'd0) : (b_i == '0)) begin
        special  = 1'b1;
        spec_res = (mdop_i inside {MD_REM, MD_REMU}) ? a_sel : '1;
      end else if ((mdop_i inside {MD_DIV, MD_REM}) &&
                   (w32_in ? (a_i[31:0] == 32'h8000_0000 && b_i[31:0] == '1)
                           : (a_i == {1'b1, 63'd0} && b_i == '1))) begin
        special  = 1'b1;
        spec_res = (mdop_i == MD_REM) ? '0 : a_sel;
      end
    end
  end

  logic [64:0]  hi_sum;
  logic [127:0] acc_nx, prod_fix;
  data_t        rem_nx, quo_nx, q_fix, r_fix, fin;
  logic         last;

  mdu_div_step u_div_step (
    .rem      (acc_q[127:64]),
    .quo      (acc_q[63:0]),
    .divisor  (opnd_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_comb begin
    hi_sum   = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opnd_q} : 65'd0);
    acc_nx   = is_div(op_q) ? {rem_nx, quo_nx} : {hi_sum, acc_q[63:1]};
    last     = cnt == (w32_q ? 6'd31 : 6'd63);
    // The W product sits in acc[95:32] after 32 steps, so its low word is [63:32].
    prod_fix = neg_q ? -acc_nx : acc_nx;
    q_fix    = neg_q ? -acc_nx[63:0] : acc_nx[63:0];
    r_fix    = sa_q ? -acc_nx[127:64] : acc_nx[127:64];
    case (op_q)
      MD_MUL:                       fin = w32_q ? sext32(prod_fix[63:32]) : prod_fix[63:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin = prod_fix[127:64];
      MD_DIV, MD_DIVU:              fin = w32_q ? sext32(q_fix[31:0]) : q_fix;
      default:                      fin = w32_q ? sext32(r_fix[31:0]) : r_fix;
    endcase
  end

  assign stall_o = (state == IDLE && start_i && !flush_i) || state == CALC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= MD_MUL;
      w32_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
      res_o   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            op_q  <= mdop_i;
            w32_q <= w32_in;
            neg_q <= sa ^ sb;
            sa_q  <= sa;
            cnt   <= '0;
            if (special) begin
              res_o   <= spec_res;
              valid_o <= 1'b1;
              state   <= DONE;
            end else begin
              opnd_q <= is_div(mdop_i) ? b_mag : a_mag;
              acc_q  <= is_div(mdop_i)
                        ? {64'd0, (w32_in ? {a_mag[31:0], 32'd0} : a_mag)}
                        : {64'd0, b_mag};
              state  <= CALC;
            end
          end
          CALC: begin
            acc_q <= acc_nx;
            cnt   <= cnt + 6'd1;
            if (last) begin
              res_o   <= fin;
              valid_o <= 1'b1;
              state   <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected result and arrival time,
// a negedge monitor pops and compares whenever valid_o is seen.
module tb_mdu;
  import mdu_pkg::*;

  logic  clk = 1'b0;
  logic  rst, start_i, flush_i, word32_i;
  mdop_t mdop_i;
  data_t a_i, b_i;
  logic  stall_o, valid_o;
  data_t res_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string  name;
    data_t  res;
    longint t;
  } exp_t;

  exp_t sb[$];

  mdu dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .mdop_i   (mdop_i),
    .word32_i (word32_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .res_o    (res_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected valid_o", {63'd0, valid_o}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, res_o, e.res);
        check({e.name, " valid time"}, $time, e.t);
      end
    end
  end

  // Drive one operation; the accept edge time is returned in t.
  task automatic accept(input string name, input mdop_t op, input logic w,
                        input data_t a, input data_t b, input data_t exp,
                        input int edges, input bit push, output longint t);
    @(negedge clk);
    mdop_i = op; word32_i = w; a_i = a; b_i = b; start_i = 1'b1;
    #1 check({name, " stall at accept"}, {63'd0, stall_o}, 64'd1);
    @(posedge clk);
    t = $time;
    if (push) sb.push_back('{name, exp, t + 10 * edges + 5});
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // edges = accept-to-valid latency in clock edges: 64, 32, or 0 for special cases.
  task automatic run(input string name, input mdop_t op, input logic w,
                     input data_t a, input data_t b, input data_t exp, input int edges);
    longint t;
    accept(name, op, w, a, b, exp, edges, 1'b1, t);
    for (int k = 0; k <= edges; k++) begin
      if (k > 0) @(negedge clk);
      #1 check({name, " stall"}, {63'd0, stall_o}, (k < edges) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    #1 check({name, " result hold"}, res_o, exp);
    check({name, " drained"}, sb.size(), 64'd0);
    sb.delete();
  endtask

  initial begin
    longint t;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; word32_i = 1'b0;
    mdop_i = MD_MUL; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    check("reset valid_o", {63'd0, valid_o}, 64'd0);
    check("reset res_o", res_o, 64'd0);
    check("reset stall_o", {63'd0, stall_o}, 64'd0);
    rst = 1'b0;

    run("MUL 3*-5",       MD_MUL,    1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 64);
    run("MULHU -1*-1",    MD_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    run("MULH -1*-1",     MD_MULH,   1'b0, '1, '1, 64'd0, 64);
    run("MULHSU -1*2",    MD_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run("MULH w32 ignored", MD_MULH, 1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 64);
    run("MULW",           MD_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);
    run("DIV 7/0",        MD_DIV,    1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("REM 7/0",        MD_REM,    1'b0, 64'd7, 64'd0, 64'd7, 0);
    run("DIV ovf",        MD_DIV,    1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0);
    run("REM ovf",        MD_REM,    1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 0);
    run("DIVW ovf",       MD_DIV,    1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0);
    run("DIVUW",          MD_DIVU,   1'b1, 64'hFFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 32);
    run("REMW -7%2",      MD_REM,    1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    run("DIV -100/7",     MD_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64);
    run("REM -100%7",     MD_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64);

    // Flush beats start in IDLE.
    @(negedge clk);
    mdop_i = MD_DIVU; word32_i = 1'b0; a_i = 64'd9; b_i = 64'd3;
    start_i = 1'b1; flush_i = 1'b1;
    #1 check("flush over start stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);

    // Flush mid-CALC kills the divide without a result.
    accept("flushed DIV", MD_DIV, 1'b0, 64'd100, 64'd7, 64'd0, 64, 1'b0, t);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush stall low", {63'd0, stall_o}, 64'd0);
    repeat (70) @(negedge clk);
    run("DIVU after flush", MD_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 64);

    // Asynchronous reset mid-CALC.
    accept("reset DIV", MD_DIV, 1'b0, 64'd100, 64'd7, 64'd0, 64, 1'b0, t);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async reset stall", {63'd0, stall_o}, 64'd0);
    check("async reset res_o", res_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    run("REMU after reset", MD_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
